cl_lsu: RTL and testbench

Load/store unit for the MEM stage of the pipelined core. It consumes the memory-op control bits produced by instruction decode (load, store, mem-op, byte-op) together with the ALU-computed address and store data. It runs a valid/ready request and response handshake with data memory, handling byte-lane steering, masking, zero-extension, misalignment and timeout. It stalls the pipeline until the access completes.

---
 rtl/cl_lsu.sv | 202 ++++++++++++++++++++
 tb/tb_cl_lsu.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cl_lsu.sv
// cl_lsu: MEM-stage load/store unit.
// Issues one data-memory access per memory instruction over a valid/ready
// request channel. It steers and masks store lanes, zero-extends byte loads,
// rejects misaligned word accesses and abandons accesses that get no response.
// The pipeline is stalled until the access reaches DONE.
//
// state | meaning
// IDLE  | waiting for a memory instruction; accept term drives stall_o
// REQ   | request presented, fields held until dmem_req_ready_i
// RESP  | waiting for dmem_resp_valid_i, timer counting
// DONE  | one result pulse is high, pipeline released
module cl_lsu #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_i,
    input  logic        is_mem_op_i,
    input  logic        is_load_op_i,
    input  logic        is_store_op_i,
    input  logic        is_byte_op_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    output logic        stall_o,
    output logic        dmem_req_valid_o,
    input  logic        dmem_req_ready_i,
    output logic [31:0] dmem_addr_o,
    output logic        dmem_we_o,
    output logic [3:0]  dmem_wmask_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_resp_valid_i,
    input  logic [31:0] dmem_resp_data_i,
    output logic        load_valid_o,
    output logic [31:0] load_data_o,
    output logic        store_done_o,
    output logic        misalign_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] addr_q;
    logic [31:0] data_q;
    logic        byte_q;
    logic        we_q;
    logic [7:0]  timer_q;
    logic [31:0] load_data_q;
    logic        load_valid_q;
    logic        store_done_q;
    logic        misalign_q;
    logic        timeout_q;

    logic        accept;
    logic        misaligned;
    logic        resp_hit;
    logic        timer_last;
    logic [3:0]  wmask_steer;
    logic [31:0] wdata_steer;
    logic [7:0]  resp_byte;

    // Loads are identified as "mem-op without store flag", so the load flag is informational only.
    logic        unused_load_flag;
    assign unused_load_flag = is_load_op_i;

    assign accept     = valid_i && is_mem_op_i;
    assign misaligned = !is_byte_op_i && (addr_i[1:0] != 2'b00);
    assign resp_hit   = (state == S_RESP) && dmem_resp_valid_i;
    assign timer_last = (timer_q == TIMER_LAST);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a response beats a timeout in the same cycle
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = misaligned ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (dmem_req_ready_i) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                if (dmem_resp_valid_i || timer_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs: stall while busy, plus the accept term in IDLE
    always_comb begin
        stall_o          = 1'b0;
        dmem_req_valid_o = 1'b0;
        case (state)
            S_IDLE: stall_o = accept;
            S_REQ: begin
                stall_o          = 1'b1;
                dmem_req_valid_o = 1'b1;
            end
            S_RESP:  stall_o = 1'b1;
            default: ;
        endcase
    end

    // Capture the instruction's operands at acceptance; they drive the request fields
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            data_q <= '0;
            byte_q <= 1'b0;
            we_q   <= 1'b0;
        end else if (state == S_IDLE && accept) begin
            addr_q <= addr_i;
            data_q <= store_data_i;
            byte_q <= is_byte_op_i;
            we_q   <= is_store_op_i;
        end
    end

    // Response timer: cleared when the request is taken, counts idle RESP cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
        end else if (state == S_REQ && dmem_req_ready_i) begin
            timer_q <= '0;
        end else if (state == S_RESP && !dmem_resp_valid_i) begin
            timer_q <= timer_q + 8'd1;
        end
    end

    // Write lane steering; byte stores replicate the byte so any lane sees it
    always_comb begin
        wmask_steer = 4'b0000;
        if (we_q) begin
            wmask_steer = byte_q ? (4'b0001 << addr_q[1:0]) : 4'b1111;
        end
        wdata_steer = byte_q ? {4{data_q[7:0]}} : data_q;
    end

    assign dmem_addr_o  = {addr_q[31:2], 2'b00};
    assign dmem_we_o    = (state == S_REQ) && we_q;
    assign dmem_wmask_o = (state == S_REQ) ? wmask_steer : 4'b0000;
    assign dmem_wdata_o = wdata_steer;

    // Byte lane selected by the low address bits for LBU
    always_comb begin
        resp_byte = dmem_resp_data_i[8*addr_q[1:0] +: 8];
    end

    // Load result register; only a response received in RESP for a read updates it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_data_q <= '0;
        end else if (resp_hit && !we_q) begin
            load_data_q <= byte_q ? {24'b0, resp_byte} : dmem_resp_data_i;
        end
    end

    // Registered completion pulses, high for the single DONE cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_valid_q <= 1'b0;
            store_done_q <= 1'b0;
            misalign_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            load_valid_q <= resp_hit && !we_q;
            store_done_q <= resp_hit && we_q;
            misalign_q   <= (state == S_IDLE) && accept && misaligned;
            timeout_q    <= (state == S_RESP) && !dmem_resp_valid_i && timer_last;
        end
    end

    assign load_valid_o = load_valid_q;
    assign load_data_o  = load_data_q;
    assign store_done_o = store_done_q;
    assign misalign_o   = misalign_q;
    assign timeout_o    = timeout_q;

endmodule

// File: tb/tb_cl_lsu.sv
// Directed testbench for cl_lsu with hand-computed expectations.
// The DUT is built with TIMEOUT_CYCLES=4 so the timeout path is short.
module tb_cl_lsu;

    logic        clk;
    logic        reset;
    logic        valid_i;
    logic        is_mem_op_i;
    logic        is_load_op_i;
    logic        is_store_op_i;
    logic        is_byte_op_i;
    logic [31:0] addr_i;
    logic [31:0] store_data_i;
    logic        stall_o;
    logic        dmem_req_valid_o;
    logic        dmem_req_ready_i;
    logic [31:0] dmem_addr_o;
    logic        dmem_we_o;
    logic [3:0]  dmem_wmask_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_resp_valid_i;
    logic [31:0] dmem_resp_data_i;
    logic        load_valid_o;
    logic [31:0] load_data_o;
    logic        store_done_o;
    logic        misalign_o;
    logic        timeout_o;

    int checks   = 0;
    int failures = 0;

    cl_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .valid_i          (valid_i),
        .is_mem_op_i      (is_mem_op_i),
        .is_load_op_i     (is_load_op_i),
        .is_store_op_i    (is_store_op_i),
        .is_byte_op_i     (is_byte_op_i),
        .addr_i           (addr_i),
        .store_data_i     (store_data_i),
        .stall_o          (stall_o),
        .dmem_req_valid_o (dmem_req_valid_o),
        .dmem_req_ready_i (dmem_req_ready_i),
        .dmem_addr_o      (dmem_addr_o),
        .dmem_we_o        (dmem_we_o),
        .dmem_wmask_o     (dmem_wmask_o),
        .dmem_wdata_o     (dmem_wdata_o),
        .dmem_resp_valid_i(dmem_resp_valid_i),
        .dmem_resp_data_i (dmem_resp_data_i),
        .load_valid_o     (load_valid_o),
        .load_data_o      (load_data_o),
        .store_done_o     (store_done_o),
        .misalign_o       (misalign_o),
        .timeout_o        (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_i       = 1'b0;
        is_mem_op_i   = 1'b0;
        is_load_op_i  = 1'b0;
        is_store_op_i = 1'b0;
        is_byte_op_i  = 1'b0;
        addr_i        = 32'h0;
        store_data_i  = 32'h0;
    endtask

    task automatic issue(input bit st, input bit bt, input logic [31:0] a, input logic [31:0] sd);
        valid_i       = 1'b1;
        is_mem_op_i   = 1'b1;
        is_load_op_i  = !st;
        is_store_op_i = st;
        is_byte_op_i  = bt;
        addr_i        = a;
        store_data_i  = sd;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"},   32'(stall_o),          32'h0);
        chk({tag, "_reqv"},    32'(dmem_req_valid_o), 32'h0);
        chk({tag, "_we"},      32'(dmem_we_o),        32'h0);
        chk({tag, "_wmask"},   32'(dmem_wmask_o),     32'h0);
        chk({tag, "_addr"},    dmem_addr_o,           32'h0);
        chk({tag, "_ldv"},     32'(load_valid_o),     32'h0);
        chk({tag, "_lddata"},  load_data_o,           32'h0);
        chk({tag, "_stdone"},  32'(store_done_o),     32'h0);
        chk({tag, "_misal"},   32'(misalign_o),       32'h0);
        chk({tag, "_tmo"},     32'(timeout_o),        32'h0);
    endtask

    // Aligned load with immediate ready and a response in the first RESP cycle
    task automatic load_simple(input string tag, input bit bt, input logic [31:0] a,
                               input logic [31:0] rdata, input logic [31:0] exp_addr,
                               input logic [31:0] exp_data);
        issue(1'b0, bt, a, 32'h0);
        dmem_req_ready_i = 1'b1;
        #1;
        chk({tag, "_t0_stall"}, 32'(stall_o),          32'h1);
        chk({tag, "_t0_reqv"},  32'(dmem_req_valid_o), 32'h0);
        tick();
        chk({tag, "_t1_reqv"},  32'(dmem_req_valid_o), 32'h1);
        chk({tag, "_t1_addr"},  dmem_addr_o,           exp_addr);
        chk({tag, "_t1_we"},    32'(dmem_we_o),        32'h0);
        chk({tag, "_t1_wmask"}, 32'(dmem_wmask_o),     32'h0);
        chk({tag, "_t1_stall"}, 32'(stall_o),          32'h1);
        tick();
        dmem_req_ready_i = 1'b0;
        chk({tag, "_t2_reqv"},  32'(dmem_req_valid_o), 32'h0);
        chk({tag, "_t2_stall"}, 32'(stall_o),          32'h1);
        dmem_resp_valid_i = 1'b1;
        dmem_resp_data_i  = rdata;
        tick();
        chk({tag, "_t3_ldv"},    32'(load_valid_o), 32'h1);
        chk({tag, "_t3_data"},   load_data_o,       exp_data);
        chk({tag, "_t3_stdone"}, 32'(store_done_o), 32'h0);
        chk({tag, "_t3_tmo"},    32'(timeout_o),    32'h0);
        chk({tag, "_t3_stall"},  32'(stall_o),      32'h0);
        idle_inputs();
        dmem_resp_valid_i = 1'b0;
        tick();
        chk({tag, "_t4_ldv"},  32'(load_valid_o), 32'h0);
        chk({tag, "_t4_hold"}, load_data_o,       exp_data);
    endtask

    task automatic misalign_op(input string tag, input bit st, input logic [31:0] a,
                               input logic [31:0] exp_load_data);
        issue(st, 1'b0, a, 32'h12345678);
        dmem_req_ready_i = 1'b1;
        #1;
        chk({tag, "_t0_stall"}, 32'(stall_o),          32'h1);
        chk({tag, "_t0_reqv"},  32'(dmem_req_valid_o), 32'h0);
        tick();
        chk({tag, "_t1_misal"},  32'(misalign_o),       32'h1);
        chk({tag, "_t1_reqv"},   32'(dmem_req_valid_o), 32'h0);
        chk({tag, "_t1_stall"},  32'(stall_o),          32'h0);
        chk({tag, "_t1_ldv"},    32'(load_valid_o),     32'h0);
        chk({tag, "_t1_stdone"}, 32'(store_done_o),     32'h0);
        idle_inputs();
        dmem_req_ready_i = 1'b0;
        tick();
        chk({tag, "_t2_misal"}, 32'(misalign_o),       32'h0);
        chk({tag, "_t2_reqv"},  32'(dmem_req_valid_o), 32'h0);
        chk({tag, "_t2_data"},  load_data_o,           exp_load_data);
    endtask

    // LW that sits in RESP for four cycles; optionally respond in the fourth
    task automatic resp_wait(input string tag, input logic [31:0] a, input bit resp_on_last,
                             input logic [31:0] rdata, input logic [31:0] exp_data);
        issue(1'b0, 1'b0, a, 32'h0);
        dmem_req_ready_i = 1'b1;
        #1;
        tick();
        chk({tag, "_req"}, 32'(dmem_req_valid_o), 32'h1);
        tick();
        dmem_req_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_resp_stall"}, 32'(stall_o),          32'h1);
            chk({tag, "_resp_tmo"},   32'(timeout_o),        32'h0);
            chk({tag, "_resp_reqv"},  32'(dmem_req_valid_o), 32'h0);
            if (i == 3 && resp_on_last) begin
                dmem_resp_valid_i = 1'b1;
                dmem_resp_data_i  = rdata;
            end
            tick();
        end
        chk({tag, "_done_tmo"},   32'(timeout_o),    resp_on_last ? 32'h0 : 32'h1);
        chk({tag, "_done_ldv"},   32'(load_valid_o), resp_on_last ? 32'h1 : 32'h0);
        chk({tag, "_done_stall"}, 32'(stall_o),      32'h0);
        chk({tag, "_done_data"},  load_data_o,       exp_data);
        idle_inputs();
        dmem_resp_valid_i = 1'b0;
        tick();
        chk({tag, "_idle_tmo"},   32'(timeout_o),    32'h0);
        chk({tag, "_idle_ldv"},   32'(load_valid_o), 32'h0);
        chk({tag, "_idle_stall"}, 32'(stall_o),      32'h0);
    endtask

    initial begin
        reset             = 1'b1;
        idle_inputs();
        dmem_req_ready_i  = 1'b0;
        dmem_resp_valid_i = 1'b0;
        dmem_resp_data_i  = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;
        tick();

        // Non-mem instruction in IDLE: no stall, no request
        valid_i = 1'b1;
        #1;
        chk("nonmem_stall", 32'(stall_o), 32'h0);
        tick();
        chk("nonmem_reqv", 32'(dmem_req_valid_o), 32'h0);
        idle_inputs();
        tick();

        load_simple("lw100",  1'b0, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0000_0100, 32'hDEAD_BEEF);
        load_simple("lbu203", 1'b1, 32'h0000_0203, 32'h1122_3344, 32'h0000_0200, 32'h0000_0011);
        load_simple("lbu201", 1'b1, 32'h0000_0201, 32'h1122_3344, 32'h0000_0200, 32'h0000_0033);
        load_simple("lbu200", 1'b1, 32'h0000_0200, 32'h1122_3344, 32'h0000_0200, 32'h0000_0044);

        // SB 0x42 with ready low for three REQ cycles
        issue(1'b1, 1'b1, 32'h0000_0042, 32'h0000_00A5);
        dmem_req_ready_i = 1'b0;
        #1;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("sb_reqv",  32'(dmem_req_valid_o), 32'h1);
            chk("sb_addr",  dmem_addr_o,           32'h0000_0040);
            chk("sb_we",    32'(dmem_we_o),        32'h1);
            chk("sb_wmask", 32'(dmem_wmask_o),     32'h4);
            chk("sb_wdata", dmem_wdata_o,          32'hA5A5_A5A5);
            chk("sb_stall", 32'(stall_o),          32'h1);
            if (i == 2) dmem_req_ready_i = 1'b1;
            tick();
        end
        dmem_req_ready_i = 1'b0;
        chk("sb_resp_reqv",  32'(dmem_req_valid_o), 32'h0);
        chk("sb_resp_stall", 32'(stall_o),          32'h1);
        dmem_resp_valid_i = 1'b1;
        dmem_resp_data_i  = 32'hFFFF_FFFF;
        tick();
        chk("sb_done_stdone", 32'(store_done_o), 32'h1);
        chk("sb_done_ldv",    32'(load_valid_o), 32'h0);
        chk("sb_done_stall",  32'(stall_o),      32'h0);
        chk("sb_done_data",   load_data_o,       32'h0000_0044);
        idle_inputs();
        dmem_resp_valid_i = 1'b0;
        tick();
        chk("sb_after_stdone", 32'(store_done_o), 32'h0);

        // SW full word with steering check
        issue(1'b1, 1'b0, 32'h0000_0048, 32'hCAFE_0123);
        dmem_req_ready_i = 1'b1;
        #1;
        tick();
        chk("sw_wmask", 32'(dmem_wmask_o), 32'hF);
        chk("sw_wdata", dmem_wdata_o,      32'hCAFE_0123);
        chk("sw_addr",  dmem_addr_o,       32'h0000_0048);
        tick();
        dmem_req_ready_i  = 1'b0;
        dmem_resp_valid_i = 1'b1;
        tick();
        chk("sw_stdone", 32'(store_done_o), 32'h1);
        idle_inputs();
        dmem_resp_valid_i = 1'b0;
        tick();

        misalign_op("sw46",  1'b1, 32'h0000_0046, 32'h0000_0044);
        misalign_op("lw101", 1'b0, 32'h0000_0101, 32'h0000_0044);

        resp_wait("tmo", 32'h0000_0300, 1'b0, 32'h0, 32'h0000_0044);

        // Stray response in IDLE
        dmem_resp_valid_i = 1'b1;
        dmem_resp_data_i  = 32'hCAFE_F00D;
        tick();
        chk("stray_ldv",   32'(load_valid_o), 32'h0);
        chk("stray_data",  load_data_o,       32'h0000_0044);
        chk("stray_stall", 32'(stall_o),      32'h0);
        dmem_resp_valid_i = 1'b0;
        tick();

        resp_wait("tmo_race", 32'h0000_0304, 1'b1, 32'h55AA_55AA, 32'h55AA_55AA);

        // Reset asserted while in REQ
        issue(1'b0, 1'b0, 32'h0000_0400, 32'h0);
        dmem_req_ready_i = 1'b0;
        #1;
        tick();
        chk("rstreq_pre_reqv", 32'(dmem_req_valid_o), 32'h1);
        idle_inputs();
        reset = 1'b1;
        #1;
        chk_all_zero("rstreq");
        tick();
        reset = 1'b0;
        tick();
        chk("rstreq_post_reqv",  32'(dmem_req_valid_o), 32'h0);
        chk("rstreq_post_stall", 32'(stall_o),          32'h0);

        // Reset asserted while in RESP, then a late response
        issue(1'b1, 1'b0, 32'h0000_0500, 32'h0000_00AA);
        dmem_req_ready_i = 1'b1;
        #1;
        tick();
        chk("rstresp_we",    32'(dmem_we_o),    32'h1);
        chk("rstresp_wmask", 32'(dmem_wmask_o), 32'hF);
        tick();
        dmem_req_ready_i = 1'b0;
        chk("rstresp_pre_stall", 32'(stall_o), 32'h1);
        idle_inputs();
        reset = 1'b1;
        #1;
        chk_all_zero("rstresp");
        tick();
        reset = 1'b0;
        dmem_resp_valid_i = 1'b1;
        dmem_resp_data_i  = 32'h0000_0099;
        tick();
        chk("rstresp_late_ldv",    32'(load_valid_o), 32'h0);
        chk("rstresp_late_stdone", 32'(store_done_o), 32'h0);
        chk("rstresp_late_data",   load_data_o,       32'h0);
        dmem_resp_valid_i = 1'b0;
        tick();
        chk("rstresp_after_stdone", 32'(store_done_o), 32'h0);
        chk("rstresp_after_stall",  32'(stall_o),      32'h0);

        // Back-to-back: a new load is accepted the cycle after the reset-recovery idle
        load_simple("lw_b2b", 1'b0, 32'h0000_0010, 32'h0BAD_F00D, 32'h0000_0010, 32'h0BAD_F00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
